// File: rtl/nios_system_button_irq.sv
// Avalon-MM push-button/switch port: synchronised inputs, per-bit edge capture, maskable level irq.
// Optional per-bit debounce filter is enabled by defining NIOS_BUTTON_DEBOUNCE_EN.
module nios_system_button_irq #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] EDGE_RESET   = '0,
    parameter logic [WIDTH-1:0] IN_RESET_VAL = '0,
    parameter int               DEBOUNCE_CYC = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("nios_system_button_irq: WIDTH must be in 1..32");
    end
    if (DEBOUNCE_CYC < 1) begin : g_debounce_check
        $error("nios_system_button_irq: DEBOUNCE_CYC must be at least 1");
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c_mask;
    logic             wr_en;
    logic             unused_wdata;

    // Upper writedata bits beyond WIDTH are deliberately ignored.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET_VAL;
            sync2 <= IN_RESET_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef NIOS_BUTTON_DEBOUNCE_EN
    localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] deb_cnt [WIDTH];

    // A bit is accepted only after it has disagreed with stable for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= IN_RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    assign stable = sync2;
`endif

    assign rise     = stable & ~stable_d;
    assign fall     = ~stable & stable_d;
    assign ev       = (edge_sel & fall) | (~edge_sel & rise);
    assign wr_en    = chipselect && !write_n;
    assign w1c_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Set has priority over a same-cycle write-one-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d    <= IN_RESET_VAL;
            edge_sel    <= EDGE_RESET;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            stable_d    <= stable;
            edgecapture <= (edgecapture & ~w1c_mask) | ev;
            irq         <= |(edgecapture & irqmask);
            if (wr_en && address == 2'd1) begin
                edge_sel <= writedata[WIDTH-1:0];
            end
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(stable);
                2'd1:    readdata <= 32'(edge_sel);
                2'd2:    readdata <= 32'(irqmask);
                default: readdata <= 32'(edgecapture);
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_button_irq.sv
// Self-checking bench for nios_system_button_irq: directed vector table, hand sequences and a
// randomized run checked every cycle against a behavioural model of the register map.
module tb_nios_system_button_irq;

    localparam int         WIDTH  = 4;
    localparam int         DEB    = 8;
    localparam logic [3:0] IN_RST = 4'hF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  in_port;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nios_system_button_irq #(
        .WIDTH        (WIDTH),
        .EDGE_RESET   (4'h0),
        .IN_RESET_VAL (IN_RST),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_port    (in_port)
    );

    // Behavioural model state: what each register should hold in the current cycle.
    logic [3:0]  m_s1, m_s2, m_stable, m_stable_prev, m_edge, m_mask, m_ec;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [3:0]  m_win[$];

    function automatic void modelReset();
        m_s1 = IN_RST; m_s2 = IN_RST; m_stable = IN_RST; m_stable_prev = IN_RST;
        m_edge = 4'h0; m_mask = 4'h0; m_ec = 4'h0; m_rd = 32'h0; m_irq = 1'b0;
        m_win = {};
        for (int k = 0; k < DEB; k++) m_win.push_back(IN_RST);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void modelEdge();
        logic [3:0] ev, w1c, nstable;
        logic       wr;
        wr  = chipselect && !write_n;
        ev  = 4'h0;
        for (int b = 0; b < 4; b++) begin
            if (m_edge[b]) ev[b] = (m_stable_prev[b] == 1'b1) && (m_stable[b] == 1'b0);
            else           ev[b] = (m_stable_prev[b] == 1'b0) && (m_stable[b] == 1'b1);
        end
        m_irq = |(m_ec & m_mask);
        case (address)
            2'd0: m_rd = {28'd0, m_stable};
            2'd1: m_rd = {28'd0, m_edge};
            2'd2: m_rd = {28'd0, m_mask};
            default: m_rd = {28'd0, m_ec};
        endcase
        w1c  = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_ec = (m_ec & ~w1c) | ev;
        if (wr && address == 2'd1) m_edge = writedata[3:0];
        if (wr && address == 2'd2) m_mask = writedata[3:0];
`ifdef NIOS_BUTTON_DEBOUNCE_EN
        // A bit flips once the last DEB synchronised samples all disagree with it.
        m_win.push_back(m_s2);
        while (m_win.size() > DEB) void'(m_win.pop_front());
        nstable = m_stable;
        for (int b = 0; b < 4; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            foreach (m_win[j]) if (m_win[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nstable[b] = ~m_stable[b];
        end
`else
        nstable = m_s1;
`endif
        m_stable_prev = m_stable;
        m_stable      = nstable;
        m_s2          = m_s1;
        m_s1          = in_port;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic we,
                                 input logic [31:0] wd, input logic [3:0] inp);
        address    = a;
        chipselect = cs;
        write_n    = !we;
        writedata  = wd;
        in_port    = inp;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_rd", readdata, m_rd);
        checkOutput("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic doReset();
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_rd", readdata, 32'h0);
        checkOutput("async_rst_irq", {31'd0, irq}, 32'h0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  inp;
        int          hold;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] cur_in;

    initial begin
        reset_n = 1'b0;
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, IN_RST);
        modelReset();
        #1;
        checkOutput("reset_rd", readdata, 32'h0);
        checkOutput("reset_irq", {31'd0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_rd_addr%0d", a), readdata, 32'h0);
        end
        address = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;

`ifndef NIOS_BUTTON_DEBOUNCE_EN
        vecs.push_back('{2'd0, 1'b0, 32'h0,        4'hF, 2, 32'hF, 1'b0});
        vecs.push_back('{2'd3, 1'b0, 32'h0,        4'hF, 2, 32'h0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 32'h0,        4'h0, 4, 32'h0, 1'b0});
        vecs.push_back('{2'd3, 1'b0, 32'h0,        4'h1, 4, 32'h1, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 32'h1,        4'h1, 1, 32'h0, 1'b0});
        vecs.push_back('{2'd2, 1'b0, 32'h0,        4'h1, 1, 32'h1, 1'b1});
        vecs.push_back('{2'd3, 1'b1, 32'h1,        4'h1, 1, 32'h1, 1'b1});
        vecs.push_back('{2'd3, 1'b0, 32'h0,        4'h1, 1, 32'h0, 1'b0});
        vecs.push_back('{2'd1, 1'b1, 32'h2,        4'h1, 1, 32'h0, 1'b0});
        vecs.push_back('{2'd3, 1'b0, 32'h0,        4'h3, 4, 32'h0, 1'b0});
        vecs.push_back('{2'd3, 1'b0, 32'h0,        4'h1, 4, 32'h2, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 32'hF,        4'h1, 1, 32'h1, 1'b0});
        vecs.push_back('{2'd2, 1'b0, 32'h0,        4'h1, 1, 32'hF, 1'b1});
        vecs.push_back('{2'd2, 1'b1, 32'h0,        4'h1, 1, 32'hF, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 32'h0,        4'h1, 1, 32'h1, 1'b0});
        vecs.push_back('{2'd0, 1'b1, 32'hFFFFFFFF, 4'h1, 2, 32'h1, 1'b0});
        vecs.push_back('{2'd3, 1'b1, 32'hFFFFFFFF, 4'h1, 2, 32'h0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 32'h0,        4'h1, 1, 32'h2, 1'b0});
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].addr, 1'b1, vecs[v].we, vecs[v].wdata, vecs[v].inp);
            repeat (vecs[v].hold) tick();
            checkOutput($sformatf("vec%0d_rd", v), readdata, vecs[v].exp_rd);
            checkOutput($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
        end

        // Rising edge on bit 0 lands in the same cycle as its write-one-to-clear.
        applyStimulus(2'd2, 1'b1, 1'b1, 32'h1, 4'h1); tick();
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 4'h0); repeat (3) tick();
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 4'h1); repeat (2) tick();
        applyStimulus(2'd3, 1'b1, 1'b1, 32'h1, 4'h1); tick();
        applyStimulus(2'd3, 1'b1, 1'b0, 32'h0, 4'h1); tick();
        checkOutput("set_wins_rd", readdata, 32'h1);
        checkOutput("set_wins_irq", {31'd0, irq}, 32'h1);

        doReset();
        applyStimulus(2'd2, 1'b1, 1'b0, 32'h0, 4'h1); repeat (2) tick();
        checkOutput("post_rst_mask", readdata, 32'h0);
        applyStimulus(2'd3, 1'b1, 1'b0, 32'h0, 4'h1); repeat (5) tick();
        checkOutput("post_rst_ec", readdata, 32'h0);
`else
        // Short glitch is rejected, a long enough level is accepted after 2 + DEB cycles.
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 4'hE); repeat (5) tick();
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 4'hF); repeat (20) tick();
        checkOutput("glitch_data", readdata, 32'hF);
        applyStimulus(2'd3, 1'b1, 1'b0, 32'h0, 4'hF); repeat (2) tick();
        checkOutput("glitch_ec", readdata, 32'h0);
        applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 4'hE); repeat (10) tick();
        checkOutput("deb_before", readdata, 32'hF);
        tick();
        checkOutput("deb_after", readdata, 32'hE);

        applyStimulus(2'd0, 1'b1, 1'b0, 32'h0, 4'hC); repeat (6) tick();
        doReset();
        repeat (10) tick();
        checkOutput("deb_rst_before", readdata, 32'hF);
        tick();
        checkOutput("deb_rst_after", readdata, 32'hC);
`endif

        cur_in = in_port;
        for (int n = 0; n < 600; n++) begin
`ifdef NIOS_BUTTON_DEBOUNCE_EN
            if ($urandom_range(0, 14) == 0) cur_in = 4'($urandom);
`else
            if ($urandom_range(0, 3) == 0) cur_in = 4'($urandom);
`endif
            applyStimulus(2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                          $urandom, cur_in);
            tick();
            if (n == 300) doReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
